// File: rtl/s15611_line_capture_if.sv
// rtl/s15611_line_capture_if.sv - pixel stream interface between line capture and downstream consumer
interface s15611_line_capture_if;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/s15611_line_capture.sv
// rtl/s15611_line_capture.sv - serial ADC pixel capture into ping-pong line buffers with stream readout
module s15611_line_capture #(
  parameter int NUMBER_OF_PIXEL = 128,
  parameter int SCLK_HALF_NCLK  = 4,
  parameter int ADC_FRAME_BITS  = 16
) (
  input  logic                         master_clock,
  input  logic                         reset,
  input  logic                         line_start,
  input  logic                         capture_trigger,
  output logic                         adc_cs_n,
  output logic                         adc_sclk,
  input  logic                         adc_miso,
  s15611_line_capture_if.master        m_axis,
  output logic                         line_drop,
  output logic                         trig_overrun,
  output logic [15:0]                  line_count
);

  localparam int HALF_W = $clog2(SCLK_HALF_NCLK);
  localparam int HP_W   = $clog2(2 * ADC_FRAME_BITS);
  localparam int IDX_W  = $clog2(NUMBER_OF_PIXEL + 1);
  localparam int RD_W   = $clog2(NUMBER_OF_PIXEL);
  localparam int ADDR_W = $clog2(2 * NUMBER_OF_PIXEL);

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(SCLK_HALF_NCLK - 1);
  localparam logic [HP_W-1:0]   HP_LAST    = HP_W'(2 * ADC_FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_END    = IDX_W'(NUMBER_OF_PIXEL);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUMBER_OF_PIXEL - 1);
  localparam logic [RD_W-1:0]   RD_PENULT  = RD_W'(NUMBER_OF_PIXEL - 2);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(NUMBER_OF_PIXEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_STORE
  } state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [11:0]         shift_q, shift_d;
  logic                trig_overrun_q, trig_overrun_d;

  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                wr_bank_q, wr_bank_d;
  logic                line_drop_q, line_drop_d;
  logic [15:0]         line_count_q, line_count_d;

  logic [RD_W-1:0]     rd_idx_q, rd_idx_d;
  logic                rd_bank_q, rd_bank_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [11:0]         tdata_q;

  logic                wr_ok, line_done, rd_start, rd_fire, rd_load;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;

  logic [11:0]         mem [0:2*NUMBER_OF_PIXEL-1];

  function automatic logic [ADDR_W-1:0] buf_addr(input logic bank, input logic [ADDR_W-1:0] idx);
    return bank ? (BANK1_BASE + idx) : idx;
  endfunction

  // Conversion sequencer: sclk runs only in CONVERT, MISO is taken on each low-to-high toggle.
  always_comb begin
    state_d        = state_q;
    half_cnt_d     = half_cnt_q;
    hp_cnt_d       = hp_cnt_q;
    sclk_d         = sclk_q;
    shift_d        = shift_q;
    trig_overrun_d = trig_overrun_q;
    case (state_q)
      ST_IDLE: begin
        half_cnt_d = '0;
        hp_cnt_d   = '0;
        sclk_d     = 1'b0;
        if (capture_trigger) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (capture_trigger) begin
          trig_overrun_d = 1'b1;
        end
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          hp_cnt_d   = hp_cnt_q + HP_W'(1);
          if (!sclk_q) begin
            shift_d = {shift_q[10:0], adc_miso};
          end
          if (hp_cnt_q == HP_LAST) begin
            state_d = ST_STORE;
            sclk_d  = 1'b0;
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end
      ST_STORE: begin
        if (capture_trigger) begin
          trig_overrun_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cs_n_d = (state_d != ST_CONVERT);
  end

  assign wr_ok     = (state_q == ST_STORE) && (wr_idx_q < IDX_END);
  assign line_done = wr_ok && (wr_idx_q == IDX_LAST);
  assign wr_addr   = buf_addr(wr_bank_q, ADDR_W'(wr_idx_q));
  assign rd_fire   = tvalid_q && m_axis.m_tready;

  // Line completion hands the filled bank over only when the reader is free; otherwise the line is lost.
  always_comb begin
    wr_idx_d     = wr_idx_q;
    wr_bank_d    = wr_bank_q;
    line_drop_d  = line_drop_q;
    line_count_d = line_count_q;
    rd_start     = 1'b0;
    if (wr_ok) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
    if (line_done) begin
      if (!tvalid_q) begin
        rd_start     = 1'b1;
        wr_bank_d    = ~wr_bank_q;
        line_count_d = line_count_q + 16'd1;
      end else begin
        line_drop_d = 1'b1;
      end
    end
    if (line_start) begin
      wr_idx_d = '0;
    end
  end

  // Output word is fetched one edge ahead of each beat so tdata is valid together with tvalid.
  always_comb begin
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    rd_load   = 1'b0;
    rd_addr   = '0;
    if (rd_start) begin
      rd_bank_d = wr_bank_q;
      rd_idx_d  = '0;
      tvalid_d  = 1'b1;
      tlast_d   = 1'b0;
      rd_load   = 1'b1;
      rd_addr   = buf_addr(wr_bank_q, '0);
    end else if (rd_fire) begin
      if (tlast_q) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end else begin
        rd_idx_d = rd_idx_q + RD_W'(1);
        tlast_d  = (rd_idx_q == RD_PENULT);
        rd_load  = 1'b1;
        rd_addr  = buf_addr(rd_bank_q, ADDR_W'(rd_idx_q + RD_W'(1)));
      end
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      half_cnt_q     <= '0;
      hp_cnt_q       <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      shift_q        <= '0;
      trig_overrun_q <= 1'b0;
      wr_idx_q       <= '0;
      wr_bank_q      <= 1'b0;
      line_drop_q    <= 1'b0;
      line_count_q   <= '0;
      rd_idx_q       <= '0;
      rd_bank_q      <= 1'b1;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      half_cnt_q     <= half_cnt_d;
      hp_cnt_q       <= hp_cnt_d;
      sclk_q         <= sclk_d;
      cs_n_q         <= cs_n_d;
      shift_q        <= shift_d;
      trig_overrun_q <= trig_overrun_d;
      wr_idx_q       <= wr_idx_d;
      wr_bank_q      <= wr_bank_d;
      line_drop_q    <= line_drop_d;
      line_count_q   <= line_count_d;
      rd_idx_q       <= rd_idx_d;
      rd_bank_q      <= rd_bank_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      if (rd_load) begin
        tdata_q <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge master_clock) begin
    if (!reset && wr_ok) begin
      mem[wr_addr] <= shift_q;
    end
  end

  assign adc_cs_n        = cs_n_q;
  assign adc_sclk        = sclk_q;
  assign m_axis.m_tdata  = {4'b0000, tdata_q};
  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tlast  = tlast_q;
  assign line_drop       = line_drop_q;
  assign trig_overrun    = trig_overrun_q;
  assign line_count      = line_count_q;

endmodule

// File: tb/tb_s15611_line_capture.sv
// tb/tb_s15611_line_capture.sv - directed and randomized checks of s15611_line_capture against a line-level model
module tb_s15611_line_capture;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        line_start;
  logic        capture_trigger;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_miso;
  logic        line_drop;
  logic        trig_overrun;
  logic [15:0] line_count;

  s15611_line_capture_if axis ();

  s15611_line_capture #(
    .NUMBER_OF_PIXEL(N),
    .SCLK_HALF_NCLK (2),
    .ADC_FRAME_BITS (16)
  ) dut (
    .master_clock   (clk),
    .reset          (reset),
    .line_start     (line_start),
    .capture_trigger(capture_trigger),
    .adc_cs_n       (adc_cs_n),
    .adc_sclk       (adc_sclk),
    .adc_miso       (adc_miso),
    .m_axis         (axis),
    .line_drop      (line_drop),
    .trig_overrun   (trig_overrun),
    .line_count     (line_count)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  int          compared = 0;
  int          mismatched = 0;
  beat_t       exp_q[$];
  logic [11:0] model_line[$];
  int          model_wr_cnt = 0;
  logic [15:0] model_count = 0;
  logic        model_drop = 0;
  logic [15:0] adc_frame = 16'h0000;
  int          sclk_rises = 0;
  int          ready_mode = 1;
  int          line_beats = 0;
  logic        stall_prev = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Serial ADC: presents the frame MSB first, advancing one bit on every falling sclk.
  initial begin
    int   bit_i;
    logic sclk_prev;
    bit_i     = 0;
    sclk_prev = 1'b0;
    adc_miso  = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_cs_n === 1'b1) begin
        bit_i    = 0;
        adc_miso = adc_frame[15];
      end else if (sclk_prev && adc_sclk === 1'b0) begin
        bit_i++;
        adc_miso = (bit_i < 16) ? adc_frame[15-bit_i] : 1'b0;
      end
      if (!sclk_prev && adc_sclk === 1'b1) sclk_rises++;
      sclk_prev = (adc_sclk === 1'b1);
    end
  end

  initial begin
    axis.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.m_tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Stream monitor: every valid cycle must show the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        line_beats = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("valid_held", axis.m_tvalid, 1);
        if (axis.m_tvalid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", axis.m_tvalid, 0);
          end else begin
            check("tdata", axis.m_tdata, exp_q[0].data);
            check("tlast", axis.m_tlast, exp_q[0].last);
            if (axis.m_tready) begin
              line_beats++;
              if (exp_q[0].last) begin
                check("beats_per_line", line_beats, N);
                line_beats = 0;
              end
              void'(exp_q.pop_front());
            end
          end
        end
        stall_prev = (axis.m_tvalid === 1'b1) && !axis.m_tready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired compared=%0d", compared);
    $fatal(1);
  end

  task automatic do_line_start();
    @(posedge clk);
    #1 line_start = 1'b1;
    @(posedge clk);
    #1 line_start = 1'b0;
    model_line.delete();
    model_wr_cnt = 0;
  endtask

  // One pixel: trigger, then decide the line's fate at the STORE cycle exactly as the reader sees it.
  task automatic capture_pixel(input logic [11:0] s);
    adc_frame = {4'($urandom), s};
    @(posedge clk);
    #1 capture_trigger = 1'b1;
    @(posedge clk);
    #1 capture_trigger = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    if (model_wr_cnt < N) begin
      model_line.push_back(s);
      model_wr_cnt++;
      if (model_wr_cnt == N) begin
        if (exp_q.size() == 0) begin
          for (int i = 0; i < N; i++) exp_q.push_back('{data: {4'h0, model_line[i]}, last: (i == N - 1)});
          model_count = model_count + 16'd1;
        end else begin
          model_drop = 1'b1;
        end
      end
    end
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    @(negedge clk);
    check({tag, "_line_count"}, line_count, model_count);
    check({tag, "_line_drop"}, line_drop, model_drop);
  endtask

  initial begin
    int rises0;
    reset = 1'b1;
    line_start = 1'b0;
    capture_trigger = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_tvalid", axis.m_tvalid, 0);
    check("rst_tlast", axis.m_tlast, 0);
    check("rst_tdata", axis.m_tdata, 0);
    check("rst_line_drop", line_drop, 0);
    check("rst_trig_overrun", trig_overrun, 0);
    check("rst_line_count", line_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Conversion timing and overrun
    adc_frame = 16'h5123;
    rises0 = sclk_rises;
    @(posedge clk);
    #1 capture_trigger = 1'b1;
    @(negedge clk);
    check("cs_n_trigger_cycle", adc_cs_n, 1);
    @(posedge clk);
    #1 capture_trigger = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      if (c == 10) capture_trigger = 1'b1;
      @(negedge clk);
      if (c == 1) check("cs_n_T+1", adc_cs_n, 0);
      if (c == 64) check("cs_n_T+64", adc_cs_n, 0);
      if (c == 65) begin
        check("cs_n_T+65", adc_cs_n, 1);
        check("sclk_T+65", adc_sclk, 0);
      end
      @(posedge clk);
      #1 capture_trigger = 1'b0;
    end
    check("sclk_rises", sclk_rises - rises0, 16);
    check("trig_overrun_set", trig_overrun, 1);
    check_flags("timing");

    // First full line, free-flowing consumer
    ready_mode = 1;
    do_line_start();
    capture_pixel(12'hA5A);
    capture_pixel(12'h001);
    capture_pixel(12'hFFF);
    capture_pixel(12'h800);
    wait_drain(50);
    check_flags("line1");
    check("line1_count_abs", line_count, 1);

    // Consumer stalled: second line held, third line dropped
    ready_mode = 0;
    @(posedge clk);
    #1;
    do_line_start();
    for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
    do_line_start();
    for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
    check_flags("stall");
    check("stall_drop_abs", line_drop, 1);
    check("stall_count_abs", line_count, 2);
    check("stall_tvalid", axis.m_tvalid, 1);
    ready_mode = 1;
    wait_drain(50);

    // Random backpressure
    ready_mode = 2;
    for (int l = 0; l < 2; l++) begin
      do_line_start();
      for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
      wait_drain(300);
    end
    check_flags("random_ready");

    // Partial line discarded by an early line_start
    ready_mode = 1;
    do_line_start();
    capture_pixel(12'($urandom));
    capture_pixel(12'($urandom));
    do_line_start();
    for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
    wait_drain(50);
    check_flags("partial");

    // Reset during a stalled stream with a conversion in flight
    ready_mode = 0;
    @(posedge clk);
    #1;
    do_line_start();
    for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
    @(posedge clk);
    #1 capture_trigger = 1'b1;
    @(posedge clk);
    #1 capture_trigger = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre_rst_cs_n", adc_cs_n, 0);
    check("pre_rst_tvalid", axis.m_tvalid, exp_q.size() != 0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_line.delete();
    model_wr_cnt = 0;
    model_count = 0;
    model_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cs_n", adc_cs_n, 1);
    check("mid_rst_sclk", adc_sclk, 0);
    check("mid_rst_tvalid", axis.m_tvalid, 0);
    check("mid_rst_tlast", axis.m_tlast, 0);
    check("mid_rst_tdata", axis.m_tdata, 0);
    check("mid_rst_line_drop", line_drop, 0);
    check("mid_rst_trig_overrun", trig_overrun, 0);
    check("mid_rst_line_count", line_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    ready_mode = 1;
    repeat (100) @(posedge clk);
    #1;
    do_line_start();
    for (int p = 0; p < N; p++) capture_pixel(12'($urandom));
    wait_drain(50);
    check_flags("after_reset");
    check("after_reset_overrun", trig_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
